// File: rtl/storage_pkg.sv
// Shared constants and helpers for the line-buffer / window-column generator.
package storage_pkg;

  localparam int DATA_W    = 8;                  // pixel width
  localparam int MAX_WIDTH = 1920;               // line-buffer depth
  localparam int X_W       = 11;                 // must be able to hold MAX_WIDTH
  localparam int Y_W       = 10;
  localparam int WIN       = 5;                  // vertical window size
  localparam int NUM_BUF   = WIN - 1;            // stored lines
  localparam int LAT       = 2;                  // input-to-output latency
  localparam int ADDR_W    = $clog2(MAX_WIDTH);
  localparam int SLOT_W    = $clog2(NUM_BUF);

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

  // Which tap feeds window row k: rows above the top border repeat the
  // topmost existing row, and pixels past the buffer depth only have tap 0.
  function automatic logic [2:0] tap_sel(input int k, input logic [Y_W-1:0] y,
                                         input logic over);
    if (over) return 3'd0;
    if (int'(y) < k) return 3'(y);
    return 3'(k);
  endfunction

endpackage

// File: rtl/storage_line_buffer.sv
// One stored line: single-port RAM with registered, read-before-write output.
module line_buffer
  import storage_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_WIDTH];

  // Read returns the contents from before this cycle's write.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/storage.sv
// Line buffers plus vertical 5-tap window column with top-border replication.
// The four line memories are used as a ring: the current line overwrites the
// slot holding the line four rows up (read first, so that row is still seen),
// which behaves like a vertical shift of the stored lines with one write each.
module storage
  import storage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_i,
  input  logic              dv_i,
  input  logic              hs_i,
  input  logic              vs_i,
  output logic              dv_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [X_W-1:0]    x_index,
  output logic [Y_W-1:0]    y_index,
  output logic [DATA_W-1:0] pix_mux,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4
);

  logic [X_W-1:0]    x_cnt_reg, x_cnt_next;
  logic [Y_W-1:0]    y_cnt_reg, y_cnt_next, y_cur;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic              dv_prev_reg;
  logic              over, line_end;
  logic [ADDR_W-1:0] mem_addr;

  sync_t             sync_reg [LAT];
  logic [DATA_W-1:0] pix_s1_reg;
  logic [X_W-1:0]    x_s1_reg;
  logic [Y_W-1:0]    y_s1_reg;
  logic [SLOT_W-1:0] slot_s1_reg;
  logic              over_s1_reg;

  logic [DATA_W-1:0] rd_data [NUM_BUF];
  logic [DATA_W-1:0] tap [WIN];
  logic [DATA_W-1:0] win [WIN];
  logic [DATA_W-1:0] win_reg [WIN];

  // Next-state of the raster counters; vs clears the row in the same cycle.
  always_comb begin
    over       = (x_cnt_reg >= X_W'(MAX_WIDTH));
    line_end   = dv_prev_reg & ~dv_i;
    x_cnt_next = '0;
    if (dv_i) x_cnt_next = over ? x_cnt_reg : x_cnt_reg + X_W'(1);
    y_cur      = vs_i ? '0 : y_cnt_reg;
    y_cnt_next = y_cur;
    if (line_end && !vs_i && (y_cnt_reg != '1)) y_cnt_next = y_cnt_reg + Y_W'(1);
    slot_next  = line_end ? slot_reg + SLOT_W'(1) : slot_reg;
    mem_addr   = over ? '0 : ADDR_W'(x_cnt_reg);
  end

  // Raster counters and ring slot of the line being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_reg   <= '0;
      y_cnt_reg   <= '0;
      slot_reg    <= '0;
      dv_prev_reg <= 1'b0;
    end else begin
      x_cnt_reg   <= x_cnt_next;
      y_cnt_reg   <= y_cnt_next;
      slot_reg    <= slot_next;
      dv_prev_reg <= dv_i;
    end
  end

  // Only the slot of the current line is written; all slots are read at x.
  for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
    logic we;
    assign we = dv_i & ~over & ~rst & (slot_reg == SLOT_W'(gi));
    line_buffer u_line_buffer (
      .clk     (clk),
      .we      (we),
      .addr    (mem_addr),
      .wr_data (y_i),
      .rd_data (rd_data[gi])
    );
  end

  // Sync delay line; stage 0 runs alongside the RAM read stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= {dv_i, hs_i, vs_i};
      for (int i = 1; i < LAT; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  // Stage 1: pixel attributes aligned with the registered RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1_reg  <= '0;
      x_s1_reg    <= '0;
      y_s1_reg    <= '0;
      slot_s1_reg <= '0;
      over_s1_reg <= 1'b0;
    end else begin
      pix_s1_reg  <= y_i;
      x_s1_reg    <= x_cnt_reg;
      y_s1_reg    <= y_cur;
      slot_s1_reg <= slot_reg;
      over_s1_reg <= over;
    end
  end

  // tap k is the line k rows up, which lives k slots behind the current one.
  assign tap[0] = pix_s1_reg;
  for (genvar gi = 1; gi < WIN; gi++) begin : g_tap
    assign tap[gi] = rd_data[slot_s1_reg - SLOT_W'(gi)];
  end

  for (genvar gi = 0; gi < WIN; gi++) begin : g_win
    assign win[gi] = tap[tap_sel(gi, y_s1_reg, over_s1_reg)];
  end

  // Stage 2: output registers, data forced to zero outside active pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_index <= '0;
      y_index <= '0;
      for (int k = 0; k < WIN; k++) win_reg[k] <= '0;
    end else begin
      y_index <= y_s1_reg;
      x_index <= '0;
      for (int k = 0; k < WIN; k++) win_reg[k] <= '0;
      if (sync_reg[0].dv) begin
        x_index <= over_s1_reg ? X_W'(MAX_WIDTH - 1) : x_s1_reg;
        for (int k = 0; k < WIN; k++) win_reg[k] <= win[k];
      end
    end
  end

  assign dv_o    = sync_reg[LAT-1].dv;
  assign hs_o    = sync_reg[LAT-1].hs;
  assign vs_o    = sync_reg[LAT-1].vs;
  assign p0      = win_reg[0];
  assign p1      = win_reg[1];
  assign p2      = win_reg[2];
  assign p3      = win_reg[3];
  assign p4      = win_reg[4];
  assign pix_mux = win_reg[2];

endmodule

// File: tb/tb_storage.sv
// Scoreboard bench: stimulus pushes expected output records, a negedge
// monitor pops one whenever the DUT presents dv_o/hs_o/vs_o.
module tb_storage;
  import storage_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] y_i = '0;
  logic              dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic              dv_o, hs_o, vs_o;
  logic [X_W-1:0]    x_index;
  logic [Y_W-1:0]    y_index;
  logic [DATA_W-1:0] pix_mux, p0, p1, p2, p3, p4;

  storage dut (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .x_index(x_index), .y_index(y_index),
    .pix_mux(pix_mux), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                         due;
    logic                       dv, hs, vs;
    logic [X_W-1:0]             x;
    logic [Y_W-1:0]             y;
    logic [WIN-1:0][DATA_W-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  logic rst_s = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Bench model of the frame: pixel value is {line_hi, col[3:0]}.
  int       y_model = 0;
  logic [3:0] hist [WIN];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic dv, input logic hs, input logic vs, input logic [DATA_W-1:0] pix);
    @(posedge clk); #1;
    dv_i = dv; hs_i = hs; vs_i = vs; y_i = pix;
  endtask

  task automatic push_sync(input logic hs, input logic vs);
    exp_t e;
    e.due = cyc + LAT; e.dv = 1'b0; e.hs = hs; e.vs = vs;
    e.x = '0; e.y = vs ? '0 : Y_W'(y_model); e.p = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_pix(input logic [3:0] hi, input int c, input logic v);
    exp_t e;
    logic [3:0] cl;
    logic over;
    int j;
    cl   = 4'(c);
    over = (c >= MAX_WIDTH);
    e.due = cyc + LAT; e.dv = 1'b1; e.hs = 1'b0; e.vs = v;
    e.x = over ? X_W'(MAX_WIDTH - 1) : X_W'(c);
    e.y = Y_W'(y_model);
    e.p[0] = {hi, cl};
    for (int k = 1; k < WIN; k++) begin
      j = (k < y_model) ? k : y_model;
      e.p[k] = (over || j == 0) ? {hi, cl} : {hist[j], cl};
    end
    // hand-computed reference points
    if (y_model == 5 && hi == 4'h5 && c == 3) e.p = {8'h13, 8'h23, 8'h33, 8'h43, 8'h53};
    if (y_model == 0 && hi == 4'h0 && c == 12) e.p = {8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C};
    if (y_model == 1 && hi == 4'h1 && c == 7) e.p = {8'h07, 8'h07, 8'h07, 8'h07, 8'h17};
    exp_q.push_back(e);
  endtask

  task automatic run_line(input logic [3:0] hi, input int width, input int vs_at);
    step(1'b0, 1'b1, 1'b0, '0); push_sync(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < width; c++) begin
      if (c == vs_at) y_model = 0;
      step(1'b1, 1'b0, (c == vs_at), {hi, 4'(c)});
      push_pix(hi, c, (c == vs_at));
    end
    step(1'b0, 1'b0, 1'b0, '0);
    for (int k = WIN - 1; k > 1; k--) hist[k] = hist[k-1];
    hist[1] = hi;
    y_model++;
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic frame_start();
    y_model = 0;
    step(1'b0, 1'b0, 1'b1, '0); push_sync(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Outputs due after the reset edge are flushed by the DUT, so drop them.
  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; y_i = '0;
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    repeat (n - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst = 1'b0;
    y_model = 0;
  endtask

  // ---------------- monitor ----------------
  exp_t m;
  logic [WIN-1:0][DATA_W-1:0] act_p;

  always @(negedge clk) begin
    act_p = {p4, p3, p2, p1, p0};
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      m = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing cyc=%0d: no output for record due=%0d x=%0d y=%0d p0=%h", cyc, m.due, m.x, m.y, m.p[0]);
    end
    if (rst_s) begin
      checks++;
      if ({dv_o, hs_o, vs_o, x_index, y_index, pix_mux, act_p} !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got dv=%b hs=%b vs=%b x=%0d y=%0d pm=%h p=%h, need all zero",
                 cyc, dv_o, hs_o, vs_o, x_index, y_index, pix_mux, act_p);
      end
    end else if (dv_o === 1'b1 || hs_o === 1'b1 || vs_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected cyc=%0d got dv=%b hs=%b vs=%b x=%0d y=%0d p=%h, need no output",
                 cyc, dv_o, hs_o, vs_o, x_index, y_index, act_p);
      end else begin
        m = exp_q.pop_front();
        if (cyc != m.due || dv_o !== m.dv || hs_o !== m.hs || vs_o !== m.vs ||
            x_index !== m.x || y_index !== m.y || act_p !== m.p || pix_mux !== m.p[2]) begin
          errors++;
          $display("FAIL txn cyc=%0d got dv=%b hs=%b vs=%b x=%0d y=%0d pm=%h p4..p0=%h, need cyc=%0d dv=%b hs=%b vs=%b x=%0d y=%0d pm=%h p4..p0=%h",
                   cyc, dv_o, hs_o, vs_o, x_index, y_index, pix_mux, act_p,
                   m.due, m.dv, m.hs, m.vs, m.x, m.y, m.p[2], m.p);
        end else begin
          $display("txn cyc=%0d dv=%b hs=%b vs=%b x=%0d y=%0d p4..p0=%h ok",
                   cyc, dv_o, hs_o, vs_o, x_index, y_index, act_p);
        end
      end
    end else begin
      checks++;
      if ({x_index, pix_mux, act_p} !== '0) begin
        errors++;
        $display("FAIL idle cyc=%0d got x=%0d pm=%h p=%h, need zero while dv_o=0",
                 cyc, x_index, pix_mux, act_p);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < WIN; k++) hist[k] = '0;
    apply_reset(2);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);

    // frame A: 10 lines x 16 pixels
    frame_start();
    for (int r = 0; r < 10; r++) run_line(4'(r), 16, -1);

    // blank lines: hs only, row count must not advance
    for (int b = 0; b < 5; b++) begin
      step(1'b0, 1'b1, 1'b0, '0); push_sync(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    end

    // frame B: rows restart at 0, no stale rows from frame A
    frame_start();
    for (int r = 0; r < 3; r++) run_line(4'(r), 16, -1);

    // frame C: lines longer than the buffer depth
    frame_start();
    for (int r = 0; r < 5; r++) run_line(4'(r), MAX_WIDTH + 3, -1);

    // vs in the middle of an active line, then the following line
    run_line(4'h5, 16, 8);
    run_line(4'h6, 16, -1);

    // reset in the middle of a line
    step(1'b0, 1'b1, 1'b0, '0); push_sync(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, 1'b0, {4'h7, 4'(c)});
      push_pix(4'h7, c, 1'b0);
    end
    apply_reset(3);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    run_line(4'hF, 16, -1);
    run_line(4'hE, 16, -1);

    repeat (10) step(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
